weight_read_sequencer: RTL and testbench

- Read-side companion to the local weight memory.
- On a start command for one CNN layer, walks every packed 128-bit weight word, drives the memory's read port(s) and captures the 1-cycle-latency SRAM output.
- Masks unused 16-bit lanes and streams words to the convolution datapath over a valid/ready handshake, with back-pressure and full throughput.

---
 rtl/cnn_weight_pkg.sv | 38 +++
 rtl/weight_out_fifo.sv | 52 +++++
 rtl/weight_read_sequencer.sv | 157 +++++++++++++++
 tb/tb_weight_read_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_weight_pkg.sv
// cnn_weight_pkg: layer codes, word counts, lane geometry and the
// FSM state encoding shared by the weight read path.
package cnn_weight_pkg;

  localparam logic [3:0] LAYER1 = 4'd1;
  localparam logic [3:0] LAYER2 = 4'd2;
  localparam logic [3:0] LAYER4 = 4'd3;
  localparam logic [3:0] LAYER5 = 4'd4;
  localparam logic [3:0] LAYER7 = 4'd5;

  localparam int L1_WORD_CNT = 72;
  localparam int LX_WORD_CNT = 72;
  localparam int L7_WORD_CNT = 25;
  localparam int L7_OFFSET   = 25;

  localparam int LANE_W   = 16;
  localparam int LANES    = 8;
  localparam int L1_LANES = 3;
  localparam int WORD_W   = LANE_W * LANES;
  localparam int ENTRY_W  = 2 * WORD_W + 1;

  localparam logic [WORD_W-1:0] L1_MASK =
    {{(WORD_W - L1_LANES * LANE_W){1'b0}},
     {(L1_LANES * LANE_W){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_STORE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic layer_ok(input logic [3:0] code);
    return (code >= LAYER1) && (code <= LAYER7);
  endfunction

endpackage

// File: rtl/weight_out_fifo.sv
// weight_out_fifo: synchronous buffer between SRAM capture and the
// weight stream; one entry = {data1, data2, last}.
module weight_out_fifo
  import cnn_weight_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // storage; stale entries are hidden by the empty mask on the head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; push with pop keeps count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_read_sequencer.sv
// weight_read_sequencer: walks a layer's weight words in SRAM and
// streams them out; WEIGHT_RD_STALL_CNT_EN adds a stall counter.
module weight_read_sequencer
  import cnn_weight_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int L1_WORDS   = L1_WORD_CNT,
  parameter int LX_WORDS   = LX_WORD_CNT,
  parameter int L7_WORDS   = L7_WORD_CNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         layer_sel,
  input  logic               weight_store_done,
  output logic               read_weight_signal,
  output logic               layer7_read_weight_signal,
  output logic [15:0]        read_weight_addr1,
  output logic [15:0]        read_weight_addr2,
  input  logic [WORD_W-1:0]  read_weight_data1,
  input  logic [WORD_W-1:0]  read_weight_data2,
  output logic               wt_valid,
  input  logic               wt_ready,
  output logic [WORD_W-1:0]  wt_data1,
  output logic [WORD_W-1:0]  wt_data2,
  output logic               wt_last,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cycles
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t              state;
  logic [3:0]          layer;
  logic [15:0]         cnt;
  logic [15:0]         last_idx;
  logic [15:0]         addr1_q;
  logic [15:0]         addr2_q;
  logic                inflight;
  logic                inflight_last;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;
  logic [WORD_W-1:0]   cap1;
  logic [WORD_W-1:0]   cap2;
  logic [31:0]         occ;
  logic                is_l1;
  logic                is_l7;
  logic                start_ok;
  logic                issue;
  logic                pop;

  assign is_l1    = (layer == LAYER1);
  assign is_l7    = (layer == LAYER7);
  assign start_ok = (state == S_IDLE) && start && layer_ok(layer_sel);
  assign last_idx = is_l7 ? 16'(L7_WORDS - 1) :
                    is_l1 ? 16'(L1_WORDS - 1) :
                            16'(LX_WORDS - 1);

  assign wt_valid = !fifo_empty;
  assign pop      = wt_valid && wt_ready;

  // a slot freed by this cycle's pop counts, so ready=1 sustains 1 word/cycle
  assign occ   = 32'(fifo_count) + 32'(inflight) - 32'(pop);
  assign issue = (state == S_FETCH) && (occ < 32'(FIFO_DEPTH));

  assign read_weight_signal        = issue;
  assign layer7_read_weight_signal = issue && is_l7;
  assign read_weight_addr1 = issue ? cnt : addr1_q;
  assign read_weight_addr2 = (issue && is_l7) ? cnt : addr2_q;

  assign cap1 = is_l1 ? (read_weight_data1 & L1_MASK) : read_weight_data1;
  assign cap2 = is_l7 ? read_weight_data2 : '0;

  assign wt_data1 = head[ENTRY_W-1 -: WORD_W];
  assign wt_data2 = head[WORD_W:1];
  assign wt_last  = head[0];

  weight_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({cap1, cap2, inflight_last}),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // sequencer FSM, read tracking and registered busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      layer         <= '0;
      cnt           <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (cnt == last_idx);
      if (issue) begin
        addr1_q <= cnt;
        if (is_l7) addr2_q <= cnt;
      end
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            layer <= layer_sel;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_WAIT_STORE;
          end
        end
        S_WAIT_STORE: begin
          if (weight_store_done) state <= S_FETCH;
        end
        S_FETCH: begin
          if (issue) begin
            if (cnt == last_idx) state <= S_DRAIN;
            else cnt <= cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          if (pop && wt_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_RD_STALL_CNT_EN
  // saturating count of stalled valid cycles during a fetch
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      stall_cycles <= '0;
    else if (busy && wt_valid && !wt_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_weight_read_sequencer.sv
// tb_weight_read_sequencer: random ready / wait stimulus against a
// queue model of the expected weight stream.
module tb_weight_read_sequencer;
  import cnn_weight_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   layer_sel = '0;
  logic         weight_store_done = 1'b1;
  logic         read_weight_signal;
  logic         layer7_read_weight_signal;
  logic [15:0]  read_weight_addr1;
  logic [15:0]  read_weight_addr2;
  logic [127:0] read_weight_data1 = '0;
  logic [127:0] read_weight_data2 = '0;
  logic         wt_valid;
  logic         wt_ready = 1'b1;
  logic [127:0] wt_data1;
  logic [127:0] wt_data2;
  logic         wt_last;
  logic         busy;
  logic         done;
  logic [15:0]  stall_cycles;

  typedef struct {
    logic [127:0] d1;
    logic [127:0] d2;
    logic         last;
  } wexp_t;

  logic [127:0] mem [80];
  wexp_t        exp_q[$];
  wexp_t        mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int issue_idx = 0;
  int outstanding = 0;
  int n_acc = 0;
  int stalls = 0;
  int done_cnt = 0;
  int cur_n = 0;
  int first_valid_cyc = -1;
  int last_acc_cyc = 0;
  bit cur_l7 = 1'b0;
  bit mon_en = 1'b0;
  bit rd_ok = 1'b1;
  bit hold_prev = 1'b0;
  bit last_acc_prev = 1'b0;
  bit rd_seen;
  logic [127:0] h_d1;
  logic [127:0] h_d2;
  logic         h_last;

  weight_read_sequencer dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .layer_sel                 (layer_sel),
    .weight_store_done         (weight_store_done),
    .read_weight_signal        (read_weight_signal),
    .layer7_read_weight_signal (layer7_read_weight_signal),
    .read_weight_addr1         (read_weight_addr1),
    .read_weight_addr2         (read_weight_addr2),
    .read_weight_data1         (read_weight_data1),
    .read_weight_data2         (read_weight_data2),
    .wt_valid                  (wt_valid),
    .wt_ready                  (wt_ready),
    .wt_data1                  (wt_data1),
    .wt_data2                  (wt_data2),
    .wt_last                   (wt_last),
    .busy                      (busy),
    .done                      (done),
    .stall_cycles              (stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: 1-cycle latency, junk when the port is not read
  always @(posedge clk) begin
    if (read_weight_signal && read_weight_addr1 < 16'd80)
      read_weight_data1 <= mem[int'(read_weight_addr1)];
    else
      read_weight_data1 <= {$urandom, $urandom, $urandom, $urandom};
    if (layer7_read_weight_signal && read_weight_addr2 < 16'd55)
      read_weight_data2 <= mem[int'(read_weight_addr2) + 25];
    else
      read_weight_data2 <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stream monitor and reference comparison
  always @(negedge clk) begin
    if (mon_en) begin
      rd_seen = read_weight_signal;
      if (read_weight_signal) begin
        chk("rd_allowed", 128'(rd_ok), 128'(1));
        chk("rd_in_range", 128'(issue_idx < cur_n), 128'(1));
        chk("raddr1", 128'(read_weight_addr1), 128'(issue_idx));
        chk("raddr_lt80", 128'(read_weight_addr1 < 16'd80), 128'(1));
        if (cur_l7) begin
          chk("ren2", 128'(layer7_read_weight_signal), 128'(1));
          chk("raddr2", 128'(read_weight_addr2), 128'(issue_idx));
        end else begin
          chk("ren2_off", 128'(layer7_read_weight_signal), 128'(0));
        end
        issue_idx++;
        outstanding++;
      end
      if (hold_prev) begin
        chk("hold_valid", 128'(wt_valid), 128'(1));
        chk("hold_d1", wt_data1, h_d1);
        chk("hold_d2", wt_data2, h_d2);
        chk("hold_last", 128'(wt_last), 128'(h_last));
      end
      if (wt_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done || last_acc_prev) begin
        chk("done_timing", 128'(done), 128'(last_acc_prev));
        if (done) done_cnt++;
      end
      last_acc_prev = 1'b0;
      if (wt_valid && wt_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 128'(1), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("wt_data1", wt_data1, mon_e.d1);
          chk("wt_data2", wt_data2, mon_e.d2);
          chk("wt_last", 128'(wt_last), 128'(mon_e.last));
          if (mon_e.last) begin
            last_acc_prev = 1'b1;
            last_acc_cyc = cyc;
          end
        end
        n_acc++;
        outstanding--;
      end
      if (wt_valid && !wt_ready) stalls++;
      if (rd_seen) chk("occupancy", 128'(outstanding <= 2), 128'(1));
      hold_prev = wt_valid && !wt_ready;
      h_d1 = wt_data1;
      h_d2 = wt_data2;
      h_last = wt_last;
    end
  end

  task automatic run_layer(input logic [3:0] code, input int mode,
                           input int wait_n, input int abort_at,
                           input bit dup);
    int d0;
    int s_cyc;
    int k;
    bit [3:0] pat;
    pat = 4'b1001;
    cur_n = (code == 4'd5) ? 25 : 72;
    cur_l7 = (code == 4'd5);
    exp_q.delete();
    for (int i = 0; i < cur_n; i++) begin
      wexp_t e;
      e.d1 = mem[i];
      if (code == 4'd1) begin
        e.d1 = '0;
        e.d1[47:0] = mem[i][47:0];
      end
      e.d2 = cur_l7 ? mem[i + 25] : '0;
      e.last = (i == cur_n - 1);
      exp_q.push_back(e);
    end
    issue_idx = 0;
    outstanding = 0;
    n_acc = 0;
    stalls = 0;
    first_valid_cyc = -1;
    d0 = done_cnt;
    if (wait_n > 0) begin
      weight_store_done = 1'b0;
      rd_ok = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b1;
    layer_sel = code;
    wt_ready = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_set", 128'(busy), 128'(1));
    if (wait_n > 0) begin
      for (int i = 0; i < wait_n; i++) begin
        @(posedge clk); #1;
      end
      weight_store_done = 1'b1;
      rd_ok = 1'b1;
      @(negedge clk);
      chk("no_rd_in_wait", 128'(read_weight_signal), 128'(0));
      @(negedge clk);
      chk("first_rd", 128'(read_weight_signal), 128'(1));
    end
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(posedge clk); #1;
      if (mode == 0) wt_ready = 1'b1;
      else if (k < 4) wt_ready = pat[k];
      else wt_ready = 1'($urandom_range(0, 1));
      if (wait_n > 0 && k == 5) weight_store_done = 1'b0;
      if (dup && k == 10) begin
        start = 1'b1;
        layer_sel = 4'd5;
      end
      if (dup && k == 11) begin
        start = 1'b0;
        @(negedge clk);
        chk("busy_dup", 128'(busy), 128'(1));
      end
      if (abort_at >= 0 && n_acc >= abort_at) begin
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctl", 128'({wt_valid, busy, done, read_weight_signal,
                             layer7_read_weight_signal, wt_last}), 128'(0));
        chk("rst_addr", 128'({read_weight_addr1, read_weight_addr2}),
            128'(0));
        chk("rst_d1", wt_data1, 128'(0));
        chk("rst_d2", wt_data2, 128'(0));
        chk("rst_stall", 128'(stall_cycles), 128'(0));
        repeat (3) begin
          @(negedge clk);
          chk("no_capture", 128'(wt_valid), 128'(0));
        end
        exp_q.delete();
        issue_idx = 0;
        outstanding = 0;
        cur_n = 0;
        hold_prev = 1'b0;
        last_acc_prev = 1'b0;
        mon_en = 1'b1;
        return;
      end
      k++;
    end
    weight_store_done = 1'b1;
    if (done_cnt == d0) chk("timeout", 128'(0), 128'(1));
    chk("words_left", 128'(exp_q.size()), 128'(0));
    chk("reads_issued", 128'(issue_idx), 128'(cur_n));
    if (mode == 0 && wait_n == 0) begin
      chk("first_valid_lat", 128'(first_valid_cyc), 128'(s_cyc + 4));
      chk("throughput", 128'(last_acc_cyc - first_valid_cyc),
          128'(cur_n - 1));
    end
    repeat (3) @(negedge clk);
    chk("busy_clear", 128'(busy), 128'(0));
    chk("one_done", 128'(done_cnt - d0), 128'(1));
`ifdef WEIGHT_RD_STALL_CNT_EN
    chk("stall_cnt", 128'(stall_cycles), 128'(stalls));
`else
    chk("stall_cnt_off", 128'(stall_cycles), 128'(0));
`endif
  endtask

  task automatic bad_start(input logic [3:0] code);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    layer_sel = code;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("bad_busy", 128'(busy), 128'(0));
    chk("bad_done", 128'(done_cnt), 128'(d0));
  endtask

  initial begin
    for (int a = 0; a < 80; a++)
      for (int k = 0; k < 8; k++)
        mem[a][16*k +: 16] = {8'($urandom), 8'(a + k)};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 128'({wt_valid, busy, done, read_weight_signal,
                           layer7_read_weight_signal, wt_last}), 128'(0));
    chk("reset_addr", 128'({read_weight_addr1, read_weight_addr2}),
        128'(0));
    chk("reset_data", wt_data1 | wt_data2, 128'(0));
    chk("reset_stall", 128'(stall_cycles), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    run_layer(4'd1, 0, 0, -1, 1'b0);
    run_layer(4'd5, 0, 0, -1, 1'b0);
    run_layer(4'd3, 1, 0, -1, 1'b0);
    run_layer(4'd4, 1, 10, -1, 1'b0);
    run_layer(4'd2, 0, 0, 30, 1'b0);
    run_layer(4'd2, 0, 0, -1, 1'b0);
    bad_start(4'd0);
    bad_start(4'(6 + $urandom_range(0, 9)));
    run_layer(4'd4, 1, 0, -1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
